// File: rtl/sec32_check_gen.sv
// Two-stage check-bit generator for the 32-bit SEC datapath, with single-bit
// error injection and a count of completed output handshakes.
module sec32_check_gen #(
  parameter int INJ_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        cfg_check_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_check,
  output logic        out_check_en,
  input  logic        inj_arm,
  input  logic [5:0]  inj_pos,
  output logic        inj_busy,
  output logic [15:0] word_cnt
);

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam logic INJ_ON = (INJ_EN != 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  function automatic logic [CHK_W-1:0] check_bits(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c[0] = ^(d & 32'h00FF_1111);
    c[1] = ^(d & 32'hFF00_2222);
    c[2] = ^(d & 32'h0F0F_4444);
    c[3] = ^(d & 32'hF0F0_8888);
    c[4] = ^(d & 32'h1111_00FF);
    c[5] = ^(d & 32'h2222_FF00);
    c[6] = ^(d & 32'h4444_0F0F);
    c[7] = ^(d & 32'h8888_F0F0);
    return c;
  endfunction

  logic                    vld_p1;
  logic [DATA_W-1:0]       data_p1;
  logic                    en_p1;
  logic                    vld_p2;
  logic [DATA_W-1:0]       data_p2;
  logic [CHK_W-1:0]        chk_p2;
  logic                    en_p2;

  logic                    adv_p1;
  logic                    adv_p2;
  logic                    move_p1;

  logic [0:0]              inj_state;
  logic [5:0]              inj_pos_q;
  logic                    flip_hit;
  logic [DATA_W+CHK_W-1:0] flip_vec;

  logic [15:0]             cnt;

  assign adv_p2   = !vld_p2 | out_ready;
  assign adv_p1   = !vld_p1 | adv_p2;
  assign move_p1  = vld_p1 & adv_p2;
  assign in_ready = adv_p1;

  // The flip lands on the word leaving S1 while armed; an arm arriving on the
  // same edge only affects the following word because the state is registered.
  assign flip_hit = INJ_ON && (inj_state == ST_ARMED) && move_p1;
  assign flip_vec = flip_hit ? ((DATA_W+CHK_W)'(1) << inj_pos_q) : '0;

  // ---- stage 1: capture input word and enable ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      data_p1 <= in_data;
      en_p1   <= cfg_check_en;
    end
  end

  // ---- stage 2: check generation, then optional single-bit flip ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      chk_p2  <= '0;
      en_p2   <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_p1 ^ flip_vec[DATA_W-1:0];
        chk_p2  <= check_bits(data_p1) ^ flip_vec[DATA_W+CHK_W-1:DATA_W];
        en_p2   <= en_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_state <= ST_IDLE;
      inj_pos_q <= '0;
    end else begin
      case (inj_state)
        ST_IDLE: begin
          if (INJ_ON && inj_arm && (inj_pos <= 6'd39)) begin
            inj_state <= ST_ARMED;
            inj_pos_q <= inj_pos;
          end
        end
        ST_ARMED: begin
          if (move_p1) inj_state <= ST_IDLE;
        end
        default: inj_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign out_valid    = vld_p2;
  assign out_data     = data_p2;
  assign out_check    = chk_p2;
  assign out_check_en = en_p2;
  assign inj_busy     = (inj_state == ST_ARMED);
  assign word_cnt     = cnt;

endmodule

// File: tb/tb_sec32_check_gen.sv
// Bench for sec32_check_gen: directed vector table, injection and reset
// sequences, a randomized scoreboard run, and the word counter wrap.
module tb_sec32_check_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        cfg_check_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        out_check_en;
  logic        inj_arm = 1'b0;
  logic [5:0]  inj_pos = '0;
  logic        inj_busy;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  sec32_check_gen #(.INJ_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_check_en(cfg_check_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_check(out_check), .out_check_en(out_check_en),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_busy(inj_busy),
    .word_cnt(word_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Data subsets of each check bit, listed by data bit index.
  int subset [8][12] = '{
    '{0, 4, 8, 12, 16, 17, 18, 19, 20, 21, 22, 23},
    '{1, 5, 9, 13, 24, 25, 26, 27, 28, 29, 30, 31},
    '{2, 6, 10, 14, 16, 17, 18, 19, 24, 25, 26, 27},
    '{3, 7, 11, 15, 20, 21, 22, 23, 28, 29, 30, 31},
    '{0, 1, 2, 3, 4, 5, 6, 7, 16, 20, 24, 28},
    '{8, 9, 10, 11, 12, 13, 14, 15, 17, 21, 25, 29},
    '{0, 1, 2, 3, 8, 9, 10, 11, 18, 22, 26, 30},
    '{4, 5, 6, 7, 12, 13, 14, 15, 19, 23, 27, 31}
  };

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] r;
    for (int c = 0; c < 8; c++) begin
      logic p;
      p = 1'b0;
      for (int k = 0; k < 12; k++) p = p ^ d[subset[c][k]];
      r[c] = p;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures from run_word.
  logic        cap_early, cap_valid, cap_en, cap_busy;
  logic [31:0] cap_data;
  logic [7:0]  cap_chk;

  task automatic run_word(input logic [31:0] d, input logic en);
    in_valid = 1'b1; in_data = d; cfg_check_en = en; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cap_early = out_valid;
    tick();
    cap_valid = out_valid; cap_data = out_data; cap_chk = out_check;
    cap_en = out_check_en; cap_busy = inj_busy;
    tick();
  endtask

  // Scoreboard: words enter on accepted input handshakes, leave on output ones.
  logic        sb_on = 1'b0;
  logic [40:0] exp_q [$];
  int          n_out = 0;
  logic        stall_prev = 1'b0;
  logic [40:0] stall_bits = '0;

  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      if (in_valid && in_ready)
        exp_q.push_back({in_data, ref_check(in_data), cfg_check_en});
      if (stall_prev && out_valid)
        check("stall_hold", 64'({out_data, out_check, out_check_en}), 64'(stall_bits));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_word", 64'(1), 64'(0));
        end else begin
          check("sb_word", 64'({out_data, out_check, out_check_en}), 64'(exp_q.pop_front()));
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_bits = {out_data, out_check, out_check_en};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] d;
    logic        en;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic        accepted;
    int          guard;
    logic [31:0] x, y;

    vecs[0] = '{32'h0000_0000, 1'b1, 8'h00};
    vecs[1] = '{32'hFFFF_FFFF, 1'b1, 8'h00};
    vecs[2] = '{32'h0000_0001, 1'b1, 8'h51};
    vecs[3] = '{32'h0001_0000, 1'b1, 8'h15};
    vecs[4] = '{32'h8000_0000, 1'b1, 8'h8A};
    vecs[5] = '{32'h0000_0001, 1'b0, 8'h51};

    // Reset state
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_bits", 64'({out_data, out_check, out_check_en}), 64'(0));
    check("rst_inj_busy", 64'(inj_busy), 64'(0));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));
    rst_n = 1'b1;
    tick();

    // Check-bit vectors with two-edge latency
    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].d, vecs[i].en);
      check($sformatf("vec%0d_early", i), 64'(cap_early), 64'(0));
      check($sformatf("vec%0d_out", i), 64'({cap_valid, cap_data, cap_chk, cap_en}),
            64'({1'b1, vecs[i].d, vecs[i].chk, vecs[i].en}));
    end
    check("vec_word_cnt", 64'(word_cnt), 64'(6));

    // Injection on check bit 3
    inj_arm = 1'b1; inj_pos = 6'd35;
    tick();
    inj_arm = 1'b0;
    check("inj35_busy", 64'(inj_busy), 64'(1));
    run_word(32'h0000_0001, 1'b1);
    check("inj35_out", 64'({cap_data, cap_chk}), 64'({32'h0000_0001, 8'h59}));
    check("inj35_busy_fall", 64'(cap_busy), 64'(0));

    // Out-of-range position is ignored
    inj_arm = 1'b1; inj_pos = 6'd40;
    tick();
    inj_arm = 1'b0;
    check("inj40_busy", 64'(inj_busy), 64'(0));
    run_word(32'h0000_0001, 1'b1);
    check("inj40_out", 64'({cap_data, cap_chk}), 64'({32'h0000_0001, 8'h51}));

    // Re-arm while armed keeps the first position (data bit 3)
    inj_arm = 1'b1; inj_pos = 6'd3;
    tick();
    inj_pos = 6'd36;
    tick();
    inj_arm = 1'b0;
    check("rearm_busy", 64'(inj_busy), 64'(1));
    run_word(32'h0000_0000, 1'b1);
    check("rearm_out", 64'({cap_data, cap_chk}), 64'({32'h0000_0008, ref_check(32'h0)}));

    // Arm on the same edge a word advances: only the next word is flipped
    x = 32'h0000_00F0; y = 32'h8000_0000;
    in_valid = 1'b1; in_data = x; cfg_check_en = 1'b1; out_ready = 1'b1;
    tick();
    in_data = y; inj_arm = 1'b1; inj_pos = 6'd0;
    tick();
    inj_arm = 1'b0; in_valid = 1'b0;
    check("simul_first", 64'({out_data, out_check, inj_busy}), 64'({x, ref_check(x), 1'b1}));
    tick();
    check("simul_second", 64'({out_data, out_check, inj_busy}), 64'({y ^ 32'h1, ref_check(y), 1'b0}));
    tick();

    // Reset mid-stream with both stages full and an injection armed
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    tick();
    inj_arm = 1'b1; inj_pos = 6'd5;
    tick();
    inj_arm = 1'b0;
    tick();
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_inj_busy", 64'(inj_busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 64'({out_valid, in_ready, inj_busy, word_cnt}), 64'({1'b0, 1'b1, 1'b0, 16'h0}));
    check("mid_rst_bits", 64'({out_data, out_check, out_check_en}), 64'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    run_word(32'h0000_0001, 1'b1);
    check("post_rst_no_flip", 64'({cap_data, cap_chk}), 64'({32'h0000_0001, 8'h51}));

    // Random traffic with random back-pressure against the scoreboard
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sb_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; out_ready = $urandom_range(0, 1) != 0;
        tick();
      end
      in_valid = 1'b1; in_data = $urandom; cfg_check_en = $urandom_range(0, 1) != 0;
      guard = 0;
      do begin
        out_ready = $urandom_range(0, 3) != 0;
        #1 accepted = in_ready;
        tick();
        guard++;
      end while (!accepted && guard < 200);
      if (!accepted) begin
        check("rand_accept_timeout", 64'(guard), 64'(0));
        break;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
      tick();
      guard++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_out_count", 64'(n_out), 64'(100));
    check("rand_word_cnt", 64'(word_cnt), 64'(100));
    sb_on = 1'b0;

    // Counter to 0xFFFF, then a wrap held off by a stall
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    out_ready = 1'b1; cfg_check_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("cnt_ffff", 64'(word_cnt), 64'(16'hFFFF));
    in_valid = 1'b1; in_data = 32'hA5A5_5A5A; cfg_check_en = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_en0_word", 64'({out_valid, out_data, out_check, out_check_en}),
          64'({1'b1, 32'hA5A5_5A5A, ref_check(32'hA5A5_5A5A), 1'b0}));
    tick();
    check("wrap_stall_hold", 64'(word_cnt), 64'(16'hFFFF));
    out_ready = 1'b1;
    tick();
    check("wrap_to_zero", 64'(word_cnt), 64'(0));
    run_word(32'h0000_0001, 1'b1);
    check("en_restored", 64'({cap_chk, cap_en}), 64'({8'h51, 1'b1}));
    check("cnt_after_wrap", 64'(word_cnt), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sec32_check_gen.md
# sec32_check_gen

Pipelined check-bit generator for the 32-bit single-error-correcting datapath. It accepts 32-bit data words over a valid/ready handshake and computes the 8 even-parity check bits that the downstream SEC corrector consumes. It presents data, check bits and the check-enable strobe to that corrector. It also provides single-bit error injection and an output word counter for exercising the corrector.

## Interface
- `INJ_EN`, default 1: 1 = error-injection logic present; 0 = `inj_arm` is ignored and `inj_busy` is tied to 0.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in 32: data bits d0..d31 (bit i = di).
- `cfg_check_en` in 1: sampled with each accepted word; carried to `out_check_en`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 32: data bits, possibly with an injected flip.
- `out_check` out 8: check bits c0..c7, possibly with an injected flip.
- `out_check_en` out 1: corrector enable for this word; 0 makes the corrector ignore `out_check`.
- `inj_arm` in 1: single-cycle request to inject one flip.
- `inj_pos` in 6: flip position; 0..31 = data bit, 32..39 = check bit (pos-32).
- `inj_busy` out 1: an injection is armed and pending.
- `word_cnt` out 16: count of completed output handshakes.

## Operation
- Each check bit is the XOR (even parity) of its 12-bit data subset:
  - c0: d0,d4,d8,d12,d16..d23
  - c1: d1,d5,d9,d13,d24..d31
  - c2: d2,d6,d10,d14,d16..d19,d24..d27
  - c3: d3,d7,d11,d15,d20..d23,d28..d31
  - c4: d0..d7,d16,d20,d24,d28
  - c5: d8..d15,d17,d21,d25,d29
  - c6: d0..d3,d8..d11,d18,d22,d26,d30
  - c7: d4..d7,d12..d15,d19,d23,d27,d31
- Pipeline stages:
  - S1 registers `in_data` and `cfg_check_en`.
  - S2 registers data, the computed check bits and the enable.
  - The `out_*` ports are driven directly from S2.
- Flow control:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv`; the path from `out_ready` to `in_ready` is combinational.
  - Stage valids load on advance; a stalled stage holds its contents.
- Injection FSM:
  - States: IDLE, ARMED.
  - IDLE→ARMED when `inj_arm=1` and `inj_pos<=39`; `inj_pos` is latched.
  - In IDLE, `inj_arm` with `inj_pos>39` is ignored.
  - In ARMED, `inj_arm` is ignored.
  - ARMED→IDLE on the cycle a valid word moves S1→S2. That word gets the latched bit inverted, applied after check generation.
  - `inj_busy = (state==ARMED)`.
- `word_cnt` increments on each cycle with `out_valid & out_ready`. It wraps from 0xFFFF to 0x0000.

## Timing
- Latency: a word accepted at edge N appears on `out_*` after edge N+1, i.e. out_valid=1 two edges after `in_valid&in_ready` is sampled, when no stall occurs.
- Throughput: one word per cycle while `out_ready=1`.
- Stalls:
  - With `out_ready=0`, both stages fill and then `in_ready=0`.
  - No word is dropped or duplicated.
  - `out_*` is stable while `out_valid=1` and `out_ready=0`.
- Reset (async assert, sync release):
  - Stage valids cleared, so `out_valid=0`.
  - `in_ready=1`, `out_data=0`, `out_check=0`, `out_check_en=0`.
  - Injection FSM in IDLE, so `inj_busy=0`.
  - `word_cnt=0`.
  - Reset mid-stream discards all in-flight words and any armed injection.
- Simultaneous events:
  - `inj_arm` on the same cycle a word advances S1→S2 while in IDLE: arm takes effect and that word is not flipped; the next advancing word is flipped.
  - A counter wrap coinciding with a stall: the counter holds.

## Test plan
- Reset: assert `rst_n=0` mid-stream -> `out_valid=0`, `in_ready=1`, `word_cnt=0`, `inj_busy=0`, with no clock edge needed.
- Check vectors, `out_ready=1`:
  - data 0x00000000 -> check 0x00
  - data 0xFFFFFFFF -> check 0x00
  - data 0x00000001 -> check 0x51
  - data 0x00010000 -> check 0x15
  - data 0x80000000 -> check 0x8A
  - each appears 2 cycles after acceptance.
- Back-to-back 100 random words with random `out_ready` toggling -> output order and values match the scoreboard, each word appears once, and `word_cnt=100`.
- Injection: arm with `inj_pos=35`, send 0x00000001 -> check 0x59 and `inj_busy` falls. Arm with `inj_pos=40` -> ignored, `inj_busy` stays 0.
- Arm during ARMED with a different `inj_pos` -> the original position is applied.
- Set `word_cnt` to 0xFFFF via 65535 words, then 1 more -> `word_cnt=0`. With `cfg_check_en=0` -> `out_check_en=0` for that word only.
